// File: rtl/fifo_arbiter_if.sv
// Bundle between N_REQ upstream fifos, the arbiter, and one downstream fifo.
// The slave modport is the arbiter side; the master modport drives requests and out_ready.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface fifo_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = `DATA_WIDTH + 1
);
  // Upstream: a word moves out of fifo i on a clock edge where req_deq[i] is high;
  // req_deq[i] is only ever raised while req_valid[i] is high. Downstream: out_enq is
  // raised only in the cycle after one in which out_ready was high, one word per cycle.
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_deq;
  logic               out_ready;
  logic               out_enq;
  logic [W-1:0]       out_d;
  logic [N_REQ-1:0]   grant;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_deq, out_enq, out_d, grant
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_deq, out_enq, out_d, grant
  );
endinterface

// File: rtl/fifo_arbiter.sv
// Round-robin burst arbiter: moves up to MAX_BURST words from one upstream fifo at a
// time into a single downstream fifo, with a one-cycle arbitration gap between owners.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module fifo_arbiter #(
  parameter int ID        = 0,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic           clk,
  input  logic           rst,
  fifo_arbiter_if.slave  bus,
  output logic           dbg_state
);
  localparam int W  = `DATA_WIDTH + 1;
  localparam int IW = $clog2(N_REQ);
  localparam logic [5:0] LAST_BEAT = 6'(MAX_BURST - 1);

  if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 64 || ID < 0) begin : g_bad_param
    $error("fifo_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state, state_n;
  logic [IW-1:0]    g, g_n;
  logic [IW-1:0]    last, last_n;
  logic [5:0]       burst_cnt, burst_cnt_n;
  logic [N_REQ-1:0] grant_q, grant_n;
  logic             out_enq_q;
  logic [W-1:0]     out_d_q;

  logic             xfer;
  logic [N_REQ-1:0] deq;
  logic [W-1:0]     word_g;
  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic [IW-1:0]    cand;
  int               cand_i;

  // Rotating search: first valid requester starting just after the previous owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    cand_i    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_i = int'(last) + k;
      if (cand_i >= N_REQ) cand_i = cand_i - N_REQ;
      cand = IW'(cand_i);
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    word_g = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (g == IW'(i)) word_g = bus.req_data[i*W +: W];
    end
  end

  always_comb begin
    state_n     = state;
    g_n         = g;
    last_n      = last;
    burst_cnt_n = burst_cnt;
    grant_n     = grant_q;
    xfer        = (state == GRANT) && bus.req_valid[g] && bus.out_ready;
    deq         = '0;
    if (xfer) deq[g] = 1'b1;
    case (state)
      IDLE: begin
        grant_n = '0;
        if (sel_found) begin
          state_n          = GRANT;
          g_n              = sel_idx;
          burst_cnt_n      = '0;
          grant_n[sel_idx] = 1'b1;
        end
      end
      GRANT: begin
        if (xfer) burst_cnt_n = burst_cnt + 6'd1;
        // Losing valid ends the burst even when the downstream is stalled.
        if (!bus.req_valid[g] || (xfer && burst_cnt == LAST_BEAT)) begin
          state_n = IDLE;
          last_n  = g;
          grant_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      g         <= '0;
      last      <= IW'(N_REQ - 1);
      burst_cnt <= '0;
      grant_q   <= '0;
      out_enq_q <= 1'b0;
      out_d_q   <= '0;
    end else begin
      state     <= state_n;
      g         <= g_n;
      last      <= last_n;
      burst_cnt <= burst_cnt_n;
      grant_q   <= grant_n;
      out_enq_q <= xfer;
      if (xfer) out_d_q <= word_g;
    end
  end

  assign bus.req_deq = deq;
  assign bus.out_enq = out_enq_q;
  assign bus.out_d   = out_d_q;
  assign bus.grant   = grant_q;
  assign dbg_state   = (state == GRANT);
endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: queues stand in for the upstream fifos, a behavioural
// owner/last/count model predicts every output each cycle, directed scenarios pin it.
module tb_fifo_arbiter;
  localparam int N  = 4;
  localparam int MB = 8;
  localparam int W  = `DATA_WIDTH + 1;

  logic clk = 1'b0;
  logic rst;
  logic dbg_state;

  fifo_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  fifo_arbiter #(.ID(1), .N_REQ(N), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] up_q [N][$];
  logic [W-1:0] exp_q [$];
  logic [N-1:0] en;
  logic         rdy_v;
  logic         rst_v;
  logic [N-1:0] deq_seen;

  int           m_owner;
  int           m_last;
  int           m_cnt;
  logic         m_enq;
  logic [W-1:0] m_d;
  logic         prev_ready;
  logic [N-1:0] exp_deq;
  logic [N-1:0] exp_grant;

  int           grant_log [$];
  int           burst_log [$];
  int           gap_log [$];
  int           idle_run;
  int           burst_cur;
  logic [N-1:0] prev_grant;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Compare process: check outputs against the model, then advance the model.
  always @(negedge clk) begin
    if (!rst) begin
      m_owner = -1;
      m_last  = N - 1;
      m_cnt   = 0;
      m_enq   = 1'b0;
      m_d     = '0;
      exp_q.delete();
    end
    exp_deq   = '0;
    exp_grant = '0;
    if (m_owner >= 0) begin
      exp_grant[m_owner] = 1'b1;
      if (bus.req_valid[m_owner] && bus.out_ready) exp_deq[m_owner] = 1'b1;
    end
    chk("req_deq", bus.req_deq, exp_deq);
    chk("grant", bus.grant, exp_grant);
    chk("out_enq", bus.out_enq, m_enq);
    chk("out_d", bus.out_d, m_d);
    chk("enq_without_ready", bus.out_enq & ~prev_ready, 1'b0);
    if (bus.out_enq) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra_word: got %0h expected none at %0t", bus.out_d, $time);
      end else begin
        logic [W-1:0] want;
        checks--;
        want = exp_q.pop_front();
        chk("sb_data", bus.out_d, want);
      end
    end

    if (bus.grant != '0 && prev_grant == '0) begin
      grant_log.push_back(onehot_idx(bus.grant));
      gap_log.push_back(idle_run);
      idle_run = 0;
    end
    if (bus.grant == '0 && prev_grant != '0) begin
      burst_log.push_back(burst_cur);
      burst_cur = 0;
    end
    if (bus.grant == '0) idle_run++;
    if (bus.req_deq != '0) burst_cur++;
    prev_grant = bus.grant;
    deq_seen   = bus.req_deq;
    prev_ready = bus.out_ready && rst;

    if (rst) begin
      m_enq = 1'b0;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (bus.req_valid[c]) begin
            m_owner = c;
            m_cnt   = 0;
            break;
          end
        end
      end else if (!bus.req_valid[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (bus.out_ready) begin
        exp_q.push_back(up_q[m_owner][0]);
        m_d   = up_q[m_owner][0];
        m_enq = 1'b1;
        m_cnt++;
        if (m_cnt == MB) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  end

  // Driver: upstream fifos pop what the DUT dequeued, then present their heads.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (deq_seen[i] && up_q[i].size() > 0) void'(up_q[i].pop_front());
    rst           = rst_v;
    bus.out_ready = rdy_v;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]       = en[i] && (up_q[i].size() > 0);
      bus.req_data[i*W +: W] = (up_q[i].size() > 0) ? up_q[i][0] : '0;
    end
  endtask

  task automatic do_reset();
    rst_v = 1'b0;
    tick();
    tick();
    for (int i = 0; i < N; i++) up_q[i].delete();
    grant_log.delete();
    burst_log.delete();
    gap_log.delete();
    idle_run  = 0;
    burst_cur = 0;
  endtask

  initial begin
    int exp_own [5];
    int pulses;
    logic [W-1:0] seen [2];

    rst = 1'b0; rst_v = 1'b0; en = '0; rdy_v = 1'b0; deq_seen = '0;
    prev_grant = '0; prev_ready = 1'b0; idle_run = 0; burst_cur = 0;
    bus.req_valid = '0; bus.req_data = '0; bus.out_ready = 1'b0;

    // Single requester, three words, downstream always ready.
    do_reset();
    chk("rst_grant", bus.grant, '0);
    chk("rst_enq", bus.out_enq, 1'b0);
    chk("rst_out_d", bus.out_d, '0);
    en = '1; rdy_v = 1'b1;
    up_q[0].push_back(W'('h0A1));
    up_q[0].push_back(W'('h0B2));
    up_q[0].push_back(W'('h0C3));
    rst_v = 1'b1;
    tick();
    tick(); @(negedge clk);
    chk("s1_grant_c1", bus.grant, 4'b0001);
    tick(); @(negedge clk);
    chk("s1_enq_c2", bus.out_enq, 1'b1); chk("s1_d_c2", bus.out_d, W'('h0A1));
    tick(); @(negedge clk);
    chk("s1_enq_c3", bus.out_enq, 1'b1); chk("s1_d_c3", bus.out_d, W'('h0B2));
    tick(); @(negedge clk);
    chk("s1_enq_c4", bus.out_enq, 1'b1); chk("s1_d_c4", bus.out_d, W'('h0C3));
    tick(); @(negedge clk);
    chk("s1_enq_c5", bus.out_enq, 1'b0); chk("s1_grant_c5", bus.grant, '0);
    chk("s1_state_c5", dbg_state, 1'b0);

    // All requesters busy: full bursts, rotating owners, one idle cycle between.
    do_reset();
    en = '1; rdy_v = 1'b1;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 20; k++) up_q[i].push_back(W'(i * 32 + k));
    rst_v = 1'b1;
    repeat (50) tick();
    exp_own = '{0, 1, 2, 3, 0};
    chk("s2_n_grants_ge5", grant_log.size() >= 5, 1'b1);
    chk("s2_n_bursts_ge5", burst_log.size() >= 5, 1'b1);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("s2_owner", grant_log[i], exp_own[i]);
    for (int i = 0; i < 5 && i < burst_log.size(); i++) chk("s2_burst_len", burst_log[i], MB);
    for (int i = 1; i < 5 && i < gap_log.size(); i++) chk("s2_gap", gap_log[i], 1);

    // Requester 2 owns the bus while out_ready goes 1,0,0,1.
    do_reset();
    en = 4'b0100; rdy_v = 1'b1;
    for (int k = 0; k < 6; k++) up_q[2].push_back(W'('h100 + k));
    rst_v = 1'b1;
    tick();
    pulses = 0;
    for (int c = 1; c <= 5; c++) begin
      rdy_v = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      tick(); @(negedge clk);
      if (c <= 4) chk("s3_grant_held", bus.grant, 4'b0100);
      if (c >= 2 && bus.out_enq) begin
        if (pulses < 2) seen[pulses] = bus.out_d;
        pulses++;
      end
    end
    chk("s3_pulses", pulses, 2);
    chk("s3_first_word", seen[0], W'('h100));
    chk("s3_second_word", seen[1], W'('h101));
    rdy_v = 1'b1;
    repeat (10) tick();

    // Requester 1 drops valid mid-burst while stalled; next owner is 2, not 0.
    do_reset();
    en = 4'b0010; rdy_v = 1'b1;
    for (int k = 0; k < 6; k++) up_q[1].push_back(W'('h040 + k));
    rst_v = 1'b1;
    tick();
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      up_q[0].push_back(W'('h010 + k));
      up_q[2].push_back(W'('h020 + k));
    end
    en = 4'b0101; rdy_v = 1'b0;
    tick(); @(negedge clk);
    chk("s4_grant_c4", bus.grant, 4'b0010); chk("s4_deq_c4", bus.req_deq, '0);
    rdy_v = 1'b1;
    tick(); @(negedge clk);
    chk("s4_grant_c5", bus.grant, '0);
    tick(); @(negedge clk);
    chk("s4_next_owner", bus.grant, 4'b0100);
    repeat (20) tick();

    // Reset in the middle of a burst after five words.
    do_reset();
    en = '1; rdy_v = 1'b1;
    for (int k = 0; k < 10; k++) up_q[0].push_back(W'('h0E0 + k));
    for (int k = 0; k < 4; k++) up_q[3].push_back(W'('h0F0 + k));
    rst_v = 1'b1;
    tick();
    repeat (5) tick();
    rst_v = 1'b0;
    tick(); @(negedge clk);
    chk("s5_rst_enq", bus.out_enq, 1'b0); chk("s5_rst_grant", bus.grant, '0);
    chk("s5_rst_deq", bus.req_deq, '0);
    tick();
    rst_v = 1'b1;
    tick(); @(negedge clk);
    chk("s5_no_stale", bus.out_enq, 1'b0);
    tick(); @(negedge clk);
    chk("s5_first_owner", bus.grant, 4'b0001);

    // Randomised traffic, then a drain with everything enabled.
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0 && up_q[i].size() < 8) up_q[i].push_back(W'($urandom));
        en[i] = ($urandom_range(0, 7) != 0);
      end
      rdy_v = ($urandom_range(0, 3) != 0);
      tick();
    end
    en = '1; rdy_v = 1'b1;
    repeat (300) tick();
    @(negedge clk);
    chk("drain_scoreboard_empty", exp_q.size(), 0);
    chk("drain_upstream_empty", up_q[0].size() + up_q[1].size() + up_q[2].size() + up_q[3].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
